ext_share_arb: RTL and testbench

//  Shares one combinational extend unit (UXTB instance: mode/sign/num -> extended) among NREQ requesters.

---
 rtl/ext_pkg.sv | 25 ++
 rtl/ext_share_arb_rr_arb.sv | 32 +++
 rtl/uxtb.sv | 30 +++
 rtl/ext_share_arb.sv | 80 ++++++++
 tb/tb_ext_share_arb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_pkg.sv
// Shared types for the extend-unit arbiter: op encoding, response record, op helper.
// No logic; no latency; no backpressure.
package ext_pkg;

    localparam int EXT_NREQ = 4;
    localparam int EXT_ID_W = $clog2(EXT_NREQ);

    // Encoding is {sign, mode}.
    typedef enum logic [1:0] {
        EXT_UXTB = 2'b00,
        EXT_UXTH = 2'b01,
        EXT_SXTB = 2'b10,
        EXT_SXTH = 2'b11
    } ext_op_t;

    typedef struct packed {
        logic [31:0]         data;
        logic [EXT_ID_W-1:0] id;
    } ext_rsp_t;

    function automatic ext_op_t ext_op(input logic mode, input logic sign);
        return ext_op_t'({sign, mode});
    endfunction

endpackage

// File: rtl/ext_share_arb_rr_arb.sv
// Round-robin pick: first requester after 'last', wrapping modulo N.
// Combinational, zero latency.
// No handshake; caller qualifies the grant with slot availability.
module rr_arb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx
);

    logic         found;
    logic [W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/uxtb.sv
// Byte/halfword zero- or sign-extend of a 32-bit operand.
// Combinational, zero latency.
// No handshake.
module uxtb
    import ext_pkg::*;
(
    input  logic        mode,
    input  logic        sign,
    input  logic [31:0] num,
    output logic [31:0] extended
);

    ext_op_t op;
    logic    unused_hi;

    assign op        = ext_op(mode, sign);
    assign unused_hi = ^num[31:16];

    always_comb begin
        extended = '0;
        case (op)
            EXT_UXTB: extended = {24'h0, num[7:0]};
            EXT_UXTH: extended = {16'h0, num[15:0]};
            EXT_SXTB: extended = {{24{num[7]}}, num[7:0]};
            EXT_SXTH: extended = {{16{num[15]}}, num[15:0]};
            default:  extended = '0;
        endcase
    end

endmodule

// File: rtl/ext_share_arb.sv
// Shares one extend unit among NREQ requesters with round-robin grant and an ID-tagged result slot.
// Latency: accepted in cycle N, result on out_* in cycle N+1; 1/cycle with out_ready held high.
// Backpressure: a stalled slot holds out_* stable, drops all req_ready and freezes the round-robin pointer.
module ext_share_arb
    import ext_pkg::*;
#(
    parameter int NREQ = EXT_NREQ,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_mode,
    input  logic [NREQ-1:0]   req_sign,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ID_W-1:0]   out_id
);

    logic [NREQ-1:0] gnt_onehot;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] last_gnt;
    logic            free;
    logic            xfer;
    logic            sel_mode;
    logic            sel_sign;
    logic [31:0]     sel_data;
    logic [31:0]     ext_data;
    logic            out_valid_q;
    ext_rsp_t        rsp_q;

    rr_arb #(
        .N (NREQ),
        .W (ID_W)
    ) u_rr_arb (
        .req        (req_valid),
        .last       (last_gnt),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign free      = !out_valid_q || out_ready;
    assign req_ready = (free && !rst) ? gnt_onehot : '0;
    assign xfer      = |req_ready;

    assign sel_mode = req_mode[gnt_idx];
    assign sel_sign = req_sign[gnt_idx];
    assign sel_data = req_data[gnt_idx*32 +: 32];

    uxtb u_uxtb (
        .mode     (sel_mode),
        .sign     (sel_sign),
        .num      (sel_data),
        .extended (ext_data)
    );

    // Pointer moves only on a real transfer so a stalled requester keeps its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rsp_q       <= '0;
            last_gnt    <= ID_W'(NREQ - 1);
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            rsp_q.data  <= ext_data;
            rsp_q.id    <= EXT_ID_W'(gnt_idx);
            last_gnt    <= gnt_idx;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = rsp_q.data;
    assign out_id    = ID_W'(rsp_q.id);

endmodule

// File: tb/tb_ext_share_arb.sv
// Bench for ext_share_arb: directed scenarios plus a random soak against a grant-order scoreboard.
module tb_ext_share_arb;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_mode;
    logic [NREQ-1:0]     req_sign;
    logic [NREQ*32-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_data;
    logic [ID_W-1:0]     out_id;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0]     data;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t exp_q[$];

    ext_share_arb #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_sign  (req_sign),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic mode, input logic sign, input logic [31:0] d);
        case ({mode, sign})
            2'b00:   return {24'h0, d[7:0]};
            2'b10:   return {16'h0, d[15:0]};
            2'b01:   return {{24{d[7]}}, d[7:0]};
            default: return {{16{d[15]}}, d[15:0]};
        endcase
    endfunction

    // Scoreboard monitor: pops on consumption, pushes on acceptance, checks hold under stall.
    logic            stall_q = 1'b0;
    logic [31:0]     hold_data;
    logic [ID_W-1:0] hold_id;

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            exp_q.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hold_data || out_id !== hold_id) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h id=%0d, need v=1 d=%h id=%0d",
                             out_valid, out_data, out_id, hold_data, hold_id);
                end
            end
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("FAIL ready_onehot: req_ready=%b", req_ready);
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                checks++;
                if (req_ready !== '0) begin
                    errors++;
                    $display("FAIL stall_ready: req_ready=%b, need 0", req_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: unexpected d=%h id=%0d", out_data, out_id);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id) begin
                        errors++;
                        $display("FAIL sb_data: got d=%h id=%0d, need d=%h id=%0d",
                                 out_data, out_id, e.data, e.id);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] === 1'b1 && req_valid[i] === 1'b1) begin
                    e.data = ref_ext(req_mode[i], req_sign[i], req_data[32*i +: 32]);
                    e.id   = ID_W'(i);
                    exp_q.push_back(e);
                end
            end
            stall_q   = (out_valid === 1'b1) && (out_ready === 1'b0);
            hold_data = out_data;
            hold_id   = out_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_mode  = '0;
        req_sign  = '0;
        req_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = '1;
        req_mode  = '0;
        req_sign  = '0;
        req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, need 0000", req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: v=%b d=%h id=%0d, need 0/0/0", out_valid, out_data, out_id);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: req_ready=%b, need 0001", req_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_ops();
        logic [31:0] exp_tbl [4];
        logic [1:0]  ms_tbl  [4];
        exp_tbl = '{32'h0000_0080, 32'h0000_8F80, 32'hFFFF_FF80, 32'hFFFF_8F80};
        ms_tbl  = '{2'b00, 2'b10, 2'b01, 2'b11};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0001;
            req_mode  = {3'b0, ms_tbl[k][1]};
            req_sign  = {3'b0, ms_tbl[k][0]};
            req_data  = {96'h0, 32'h0000_8F80};
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL ops_ready[%0d]: req_ready=%b, need 0001", k, req_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tbl[k] || out_id !== 2'd0) begin
                errors++;
                $display("FAIL ops_result[%0d]: v=%b d=%h id=%0d, need 1/%h/0",
                         k, out_valid, out_data, out_id, exp_tbl[k]);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'hFFFF_8F80 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL drain_hold: v=%b d=%h id=%0d, need 0/ffff8f80/0", out_valid, out_data, out_id);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        out_ready = 1'b1;
        req_valid = '1;
        req_mode  = '0;
        req_sign  = '0;
        req_data  = {32'hA0A0_A033, 32'hA0A0_A022, 32'hA0A0_A011, 32'hA0A0_A000};
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                errors++;
                $display("FAIL rot_ready[%0d]: req_ready=%b", k, req_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_id !== ID_W'(k % 4)) begin
                errors++;
                $display("FAIL rot_id[%0d]: v=%b id=%0d, need 1/%0d", k, out_valid, out_id, k % 4);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        req_valid = 4'b0001;
        req_data  = {96'h0, 32'h1234_5678};
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_fill: req_ready=%b, need 0001", req_ready);
        end
        tick();
        req_valid = 4'b0100;
        req_mode  = 4'b0100;
        req_sign  = 4'b0100;
        req_data  = {32'h0, 32'h0000_80F0, 64'h0};
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 32'h0000_0078 || out_id !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rdy=%b v=%b d=%h id=%0d, need 0000/1/00000078/0",
                         k, req_ready, out_valid, out_data, out_id);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release: req_ready=%b, need 0100", req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_80F0 || out_id !== 2'd2) begin
            errors++;
            $display("FAIL bp_result: v=%b d=%h id=%0d, need 1/ffff80f0/2", out_valid, out_data, out_id);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_late_joiner();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b1000;
        req_mode  = 4'b1000;
        req_sign  = 4'b1000;
        req_data  = {32'h0000_7FFF, 96'h0};
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL join_ready3: req_ready=%b, need 1000", req_ready);
        end
        tick();
        checks++;
        if (out_data !== 32'h0000_7FFF || out_id !== 2'd3) begin
            errors++;
            $display("FAIL join_res3: d=%h id=%0d, need 00007fff/3", out_data, out_id);
        end
        req_valid = 4'b1010;
        req_data  = {32'h0000_7FFF, 32'h0, 32'h0000_00AB, 32'h0};
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL join_ready1: req_ready=%b, need 0010", req_ready);
        end
        tick();
        checks++;
        if (out_data !== 32'h0000_00AB || out_id !== 2'd1) begin
            errors++;
            $display("FAIL join_res1: d=%h id=%0d, need 000000ab/1", out_data, out_id);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0110;
        req_data  = {32'h0, 32'h0000_0022, 32'h0000_0011, 32'h0};
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_ready: rdy=%b v=%b, need 0000/1", req_ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst_state: v=%b d=%h id=%0d, need 0/0/0", out_valid, out_data, out_id);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_rst_grant: req_ready=%b, need 0010", req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 32'h0000_0011) begin
            errors++;
            $display("FAIL mid_rst_result: v=%b d=%h id=%0d, need 1/00000011/1", out_valid, out_data, out_id);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_soak();
        logic [NREQ-1:0] acc;
        do_reset();
        acc = '0;
        for (int n = 0; n < 10000; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i]         = 1'($urandom_range(0, 1));
                    req_mode[i]          = 1'($urandom);
                    req_sign[i]          = 1'($urandom);
                    req_data[32*i +: 32] = $urandom;
                end
            end
            #1;
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL soak_lost: %0d responses outstanding, need 0", exp_q.size());
        end
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        test_reset();
        test_ops();
        test_rotation();
        test_back_to_back();
        test_late_joiner();
        test_reset_midflight();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
